// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART blocks: oversampling ratio,
//               majority-vote sample points, receiver state encoding and the
//               3-input majority helper.
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_W   = $clog2(OVERSAMPLE);

    // Ticks within one bit period at which the line is sampled for the vote,
    // and the tick that closes the bit period.
    localparam logic [SAMPLE_W-1:0] SAMPLE_A  = 4'd7;
    localparam logic [SAMPLE_W-1:0] SAMPLE_B  = 4'd8;
    localparam logic [SAMPLE_W-1:0] SAMPLE_C  = 4'd9;
    localparam logic [SAMPLE_W-1:0] LAST_TICK = 4'd15;

    // Receiver state encoding
    localparam int            STATE_W  = 3;
    localparam logic [2:0]    ST_IDLE  = 3'd0;
    localparam logic [2:0]    ST_START = 3'd1;
    localparam logic [2:0]    ST_DATA  = 3'd2;
    localparam logic [2:0]    ST_STOP  = 3'd3;
    localparam logic [2:0]    ST_BREAK = 3'd4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Serial line plus received-byte outputs of the UART receiver.
//               master : line driver / byte consumer side
//               slave  : receiver side (uart_rx)
//   rx       serial line, idles high
//   rx_data  last good byte, LSB received first
//   rx_done  one-cycle pulse, rx_data valid in the same cycle
//   rx_error one-cycle pulse on framing error
//   rx_busy  high while a frame is being received
// Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_error;
    logic       rx_busy;

    modport master (output rx, input rx_data, input rx_done, input rx_error, input rx_busy);
    modport slave  (input rx, output rx_data, output rx_done, output rx_error, output rx_busy);
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Oversample tick generator. Counts CLK_DIV-1 down to 0 and
//               emits a one-clock tick while the count is 0. restart reloads
//               the count so the next tick is a full CLK_DIV clocks away.
//   clk, rst  clock, asynchronous active-high reset
//   restart   reload the divider
//   tick      one-clock oversample strobe
// Revision    : 1.0  initial release
// ============================================================================
module uart_baud_gen #(
    parameter int CLK_DIV = 27
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic restart,
    output logic      tick
);

    localparam int            c_cnt_w  = $clog2(CLK_DIV);
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == '0)) begin
            r_cnt <= c_reload;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tick = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, 16x oversampled, majority vote of three
//               mid-bit samples, false-start rejection and framing-error
//               reporting with break handling.
//   clk, rst  clock, asynchronous active-high reset
//   bus       uart_rx_if.slave : rx in; rx_data/rx_done/rx_error/rx_busy out
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 27
) (
    input  wire logic  clk,
    input  wire logic  rst,
    uart_rx_if.slave   bus
);

    logic                r_sync1, r_rxs;
    logic [STATE_W-1:0]  r_state, w_state_nxt;
    logic [SAMPLE_W-1:0] r_sample, w_sample_nxt;
    logic [2:0]          r_bit_idx;
    logic                r_vote_a, r_vote_b;
    logic [7:0]          r_shift, r_data;
    logic                r_done, r_error;

    logic w_tick, w_vote, w_at_c, w_at_last;
    logic w_restart, w_shift_en, w_done_set, w_error_set, w_busy;

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // "Tick N" is the tick that advances the sample counter to N. The counter
    // is cleared on start detection, so the detection itself is tick 0 of the
    // start bit and tick 9 lands 9/16 into every bit.
    assign w_sample_nxt = r_sample + 1'b1;
    assign w_at_c       = w_tick && (w_sample_nxt == SAMPLE_C);
    assign w_at_last    = w_tick && (w_sample_nxt == LAST_TICK);
    // At tick 9 the third sample is the live synchronized line.
    assign w_vote       = maj3(r_vote_a, r_vote_b, r_rxs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_rxs   <= r_sync1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (!r_rxs) w_state_nxt = ST_START;
            ST_START: begin
                if (w_at_c && w_vote)  w_state_nxt = ST_IDLE;
                else if (w_at_last)    w_state_nxt = ST_DATA;
            end
            ST_DATA:  if (w_at_last && (r_bit_idx == 3'd7)) w_state_nxt = ST_STOP;
            // Leaving at mid-stop-bit leaves half a bit to catch the next start.
            ST_STOP:  if (w_at_c) w_state_nxt = w_vote ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (r_rxs) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_restart   = 1'b0;
        w_shift_en  = 1'b0;
        w_done_set  = 1'b0;
        w_error_set = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy    = 1'b0;
                w_restart = !r_rxs;
            end
            ST_DATA:  w_shift_en = w_at_c;
            ST_STOP: begin
                w_done_set  = w_at_c && w_vote;
                w_error_set = w_at_c && !w_vote;
            end
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample  <= '0;
            r_bit_idx <= 3'd0;
            r_vote_a  <= 1'b1;
            r_vote_b  <= 1'b1;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            if (w_restart) begin
                r_sample <= '0;
            end else if (w_tick) begin
                r_sample <= w_sample_nxt;
            end

            if (w_tick && (w_sample_nxt == SAMPLE_A)) r_vote_a <= r_rxs;
            if (w_tick && (w_sample_nxt == SAMPLE_B)) r_vote_b <= r_rxs;

            if (w_restart) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == ST_DATA) && w_at_last) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            // LSB arrives first, so each new bit enters at the MSB.
            if (w_shift_en) r_shift <= {w_vote, r_shift[7:1]};
            if (w_done_set) r_data  <= r_shift;

            r_done  <= w_done_set;
            r_error <= w_error_set;
        end
    end

    assign bus.rx_data  = r_data;
    assign bus.rx_done  = r_done;
    assign bus.rx_error = r_error;
    assign bus.rx_busy  = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx (CLK_DIV=4, 64 clocks/bit).
//               Directed sequences, a vector table and randomized frames
//               checked against a frame-level expectation model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_div = 4;
    localparam int c_bit = 16 * c_div;

    logic clk = 1'b0;
    logic rst;
    uart_rx_if bus();

    always #5 clk = ~clk;

    uart_rx #(.CLK_DIV(c_div)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation of DUT pulses
    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         excl_bad = 0;
    int         last_done_cyc = 0;
    logic       prev_pulse = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (bus.rx_done) begin
            got_q.push_back(bus.rx_data);
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (bus.rx_error) err_cnt++;
        if (bus.rx_done && bus.rx_error) excl_bad++;
        if ((bus.rx_done || bus.rx_error) && prev_pulse) excl_bad++;
        prev_pulse = bus.rx_done || bus.rx_error;
    end

    int t_start = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_pop(input string nm, input logic [7:0] exp);
        if (got_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no byte received, expected %02h", nm, exp);
        end else begin
            check(nm, {24'd0, got_q.pop_front()}, {24'd0, exp});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rx = 1'b1;
        end
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rx = 1'b0;
        end
    endtask

    // Drives start, 8 data bits LSB first, stop. flip inverts the line around
    // the tick-8 sample of every data bit; nbits truncates the frame.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit flip,
                              input int len, input int nbits);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) t_start = cyc;
                bus.rx = bits[b] ^ (flip && b >= 1 && b <= 8 && c >= 31 && c <= 33);
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop;
        bit         flip;
        int         len;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_data;
    logic [7:0] exp_q[$];
    int         d0, e0, lat, n_exp_done, n_exp_err;

    initial begin
        vecs[0] = '{8'h78, 1'b1, 1'b1, 64, 1, 0};
        vecs[1] = '{8'h5A, 1'b0, 1'b0, 64, 0, 1};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 62, 1, 0};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 66, 1, 0};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 63, 1, 0};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 65, 0, 1};

        // 1: reset state and quiet idle line
        rst    = 1'b1;
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data",  {24'd0, bus.rx_data}, 32'h00);
        check("rst_done",  {31'd0, bus.rx_done}, 32'd0);
        check("rst_error", {31'd0, bus.rx_error}, 32'd0);
        check("rst_busy",  {31'd0, bus.rx_busy}, 32'd0);
        rst = 1'b0;
        idle(2000);
        check("idle_done_cnt", done_cnt, 0);
        check("idle_err_cnt",  err_cnt, 0);
        check("idle_busy",     {31'd0, bus.rx_busy}, 32'd0);
        exp_data = 8'h00;

        // 2: single frame and its latency
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hD5, 1'b1, 1'b0, c_bit, 10);
        idle(20);
        check("d5_done_cnt", done_cnt - d0, 1);
        check("d5_err_cnt",  err_cnt - e0, 0);
        check_pop("d5_byte", 8'hD5);
        check("d5_rx_data", {24'd0, bus.rx_data}, 32'hD5);
        lat = last_done_cyc - t_start;
        check("d5_latency_615pm4", {31'd0, (lat >= 611 && lat <= 619)}, 32'd1);
        exp_data = 8'hD5;

        // 3: back-to-back frames, no idle gap
        d0 = done_cnt;
        send_frame(8'h03, 1'b1, 1'b0, c_bit, 10);
        send_frame(8'hCC, 1'b1, 1'b0, c_bit, 10);
        send_frame(8'h00, 1'b1, 1'b0, c_bit, 10);
        idle(20);
        check("b2b_done_cnt", done_cnt - d0, 3);
        check_pop("b2b_byte0", 8'h03);
        check_pop("b2b_byte1", 8'hCC);
        check_pop("b2b_byte2", 8'h00);
        exp_data = 8'h00;

        // 4: 12-clock glitch is a false start
        d0 = done_cnt; e0 = err_cnt;
        for (int c = 0; c < c_bit; c++) begin
            @(negedge clk);
            if (c == 0) t_start = cyc;
            bus.rx = (c < 12) ? 1'b0 : 1'b1;
            if (c == 6)  check("glitch_busy_rise", {31'd0, bus.rx_busy}, 32'd1);
            if (c == 45) check("glitch_busy_fall", {31'd0, bus.rx_busy}, 32'd0);
        end
        idle(700);
        check("glitch_done_cnt", done_cnt - d0, 0);
        check("glitch_err_cnt",  err_cnt - e0, 0);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt; e0 = err_cnt;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].flip, vecs[i].len, 10);
            idle(40);
            check($sformatf("vec%0d_done_cnt", i), done_cnt - d0, vecs[i].exp_done);
            check($sformatf("vec%0d_err_cnt", i),  err_cnt - e0,  vecs[i].exp_err);
            if (vecs[i].exp_done == 1) begin
                check_pop($sformatf("vec%0d_byte", i), vecs[i].data);
                exp_data = vecs[i].data;
            end
            check($sformatf("vec%0d_rx_data", i), {24'd0, bus.rx_data}, {24'd0, exp_data});
        end

        // 5: framing error, held break, then recovery
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h55, 1'b0, 1'b0, c_bit, 10);
        hold_low(20 * c_bit);
        check("brk_err_cnt",  err_cnt - e0, 1);
        check("brk_done_cnt", done_cnt - d0, 0);
        check("brk_rx_data",  {24'd0, bus.rx_data}, {24'd0, exp_data});
        check("brk_busy",     {31'd0, bus.rx_busy}, 32'd1);
        idle(50);
        check("brk_busy_clear", {31'd0, bus.rx_busy}, 32'd0);
        send_frame(8'h1F, 1'b1, 1'b0, c_bit, 10);
        idle(20);
        check("brk_recover_done", done_cnt - d0, 1);
        check_pop("brk_recover_byte", 8'h1F);
        exp_data = 8'h1F;

        // 6: reset in the middle of a frame
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hF3, 1'b1, 1'b0, c_bit, 5);
        @(negedge clk);
        rst    = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_rx_data", {24'd0, bus.rx_data}, 32'h00);
        check("midrst_busy",    {31'd0, bus.rx_busy}, 32'd0);
        rst = 1'b0;
        exp_data = 8'h00;
        idle(30);
        send_frame(8'h3B, 1'b1, 1'b0, c_bit, 10);
        idle(20);
        check("midrst_done_cnt", done_cnt - d0, 1);
        check("midrst_err_cnt",  err_cnt - e0, 0);
        check_pop("midrst_byte", 8'h3B);
        exp_data = 8'h3B;

        // Randomized frames with +/-3% bit-period mismatch
        d0 = done_cnt; e0 = err_cnt;
        n_exp_done = 0; n_exp_err = 0;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] rd;
            bit         rstop;
            int         rlen, rgap;
            rd    = 8'($urandom);
            rstop = ($urandom_range(0, 7) != 0);
            rlen  = int'($urandom_range(62, 66));
            rgap  = rstop ? int'($urandom_range(0, 16)) : int'($urandom_range(4, 16));
            send_frame(rd, rstop, 1'b0, rlen, 10);
            if (rstop) begin
                exp_q.push_back(rd);
                exp_data = rd;
                n_exp_done++;
            end else begin
                n_exp_err++;
            end
            idle(rgap);
        end
        idle(40);
        check("rand_done_cnt", done_cnt - d0, n_exp_done);
        check("rand_err_cnt",  err_cnt - e0,  n_exp_err);
        while (exp_q.size() > 0) check_pop("rand_byte", exp_q.pop_front());
        check("rand_rx_data", {24'd0, bus.rx_data}, {24'd0, exp_data});

        check("done_error_exclusive", excl_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
